// File: rtl/mac_dot_pe.sv
// mac_dot_pe: LANES-wide dot-product MAC that accumulates acc_len beats per window, 2-stage pipeline.
// Build option: define MAC_DOT_PE_SATURATE_EN to clamp results instead of wrapping.
module mac_dot_pe #(
    parameter int IN_BITWIDTH  = 16,
    parameter int OUT_BITWIDTH = 32,
    parameter int LANES        = 4,
    parameter int LEN_W        = 8,
    parameter int SIGNED       = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*IN_BITWIDTH-1:0] a_in,
    input  logic [LANES*IN_BITWIDTH-1:0] w_in,
    input  logic [OUT_BITWIDTH-1:0]      psum_in,
    input  logic [LEN_W-1:0]             acc_len,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_BITWIDTH-1:0]      out,
    output logic                         ovf,
    output logic                         busy
);

    localparam int PW   = 2 * IN_BITWIDTH;
    localparam int SUMW = PW + $clog2(LANES);
    localparam int W    = ((OUT_BITWIDTH > SUMW) ? OUT_BITWIDTH : SUMW) + 1;

    function automatic logic [W-1:0] ext_prod(input logic [PW-1:0] p);
        if (SIGNED != 0) ext_prod = {{(W-PW){p[PW-1]}}, p};
        else             ext_prod = {{(W-PW){1'b0}}, p};
    endfunction

    function automatic logic [W-1:0] ext_out(input logic [OUT_BITWIDTH-1:0] v);
        if (SIGNED != 0) ext_out = {{(W-OUT_BITWIDTH){v[OUT_BITWIDTH-1]}}, v};
        else             ext_out = {{(W-OUT_BITWIDTH){1'b0}}, v};
    endfunction

    logic [LEN_W-1:0]        beat_cnt_r, len_r, len_eff_s;
    logic                    first_s, last_s, accept_s, stall_s, adv_s;
    logic [PW-1:0]           prod_s [LANES];
    logic [PW-1:0]           s1_prod_r [LANES];
    logic                    s1_valid_r, s1_first_r, s1_last_r;
    logic [OUT_BITWIDTH-1:0] s1_psum_r, acc_r, out_r, r_s;
    logic                    ovf_win_r, ovf_r, out_valid_r, ovf_add_s, win_ovf_s;
    logic [W-1:0]            lane_sum_s, base_s, r_full_s;
    logic [W-OUT_BITWIDTH:0] hi_s;

    // Per-lane multipliers feeding stage 1.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        if (SIGNED != 0) begin : g_signed
            logic signed [PW-1:0] a_ext_s, w_ext_s;
            assign a_ext_s   = PW'($signed(a_in[g*IN_BITWIDTH +: IN_BITWIDTH]));
            assign w_ext_s   = PW'($signed(w_in[g*IN_BITWIDTH +: IN_BITWIDTH]));
            assign prod_s[g] = a_ext_s * w_ext_s;
        end else begin : g_unsigned
            logic [PW-1:0] a_ext_s, w_ext_s;
            assign a_ext_s   = PW'(a_in[g*IN_BITWIDTH +: IN_BITWIDTH]);
            assign w_ext_s   = PW'(w_in[g*IN_BITWIDTH +: IN_BITWIDTH]);
            assign prod_s[g] = a_ext_s * w_ext_s;
        end
    end

    // Only a last beat waiting on a held result blocks the pipe; non-last beats keep flowing.
    assign stall_s   = out_valid_r && !out_ready && s1_valid_r && s1_last_r;
    assign in_ready  = !stall_s;
    assign accept_s  = in_valid && !stall_s;
    assign adv_s     = s1_valid_r && !stall_s;
    assign first_s   = (beat_cnt_r == '0);
    assign len_eff_s = first_s ? ((acc_len == '0) ? LEN_W'(1) : acc_len) : len_r;
    assign last_s    = (beat_cnt_r == (len_eff_s - LEN_W'(1)));
    assign busy      = (beat_cnt_r != '0) || s1_valid_r || out_valid_r;
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign ovf       = ovf_r;

    // Window beat counter and latched window length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt_r <= '0;
            len_r      <= '0;
        end else if (accept_s) begin
            if (last_s) beat_cnt_r <= '0;
            else        beat_cnt_r <= beat_cnt_r + LEN_W'(1);
            if (first_s) len_r <= len_eff_s;
        end
    end

    // Stage 1: registered products and beat flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_psum_r  <= '0;
            for (int i = 0; i < LANES; i++) s1_prod_r[i] <= '0;
        end else if (!stall_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_prod_r  <= prod_s;
                s1_first_r <= first_s;
                s1_last_r  <= last_s;
                s1_psum_r  <= psum_in;
            end
        end
    end

    // Stage 2 datapath: lane reduction, accumulate, range check and wrap/clamp.
    always_comb begin
        lane_sum_s = '0;
        for (int i = 0; i < LANES; i++) lane_sum_s = lane_sum_s + ext_prod(s1_prod_r[i]);
        base_s   = s1_first_r ? ext_out(s1_psum_r) : ext_out(acc_r);
        r_full_s = base_s + lane_sum_s;
        hi_s     = r_full_s[W-1:OUT_BITWIDTH-1];
        if (SIGNED != 0) ovf_add_s = !((hi_s == '0) || (&hi_s));
        else             ovf_add_s = (hi_s[W-OUT_BITWIDTH:1] != '0);
        r_s = r_full_s[OUT_BITWIDTH-1:0];
`ifdef MAC_DOT_PE_SATURATE_EN
        if (ovf_add_s) begin
            if (SIGNED == 0)             r_s = {OUT_BITWIDTH{1'b1}};
            else if (r_full_s[W-1])      r_s = {1'b1, {(OUT_BITWIDTH-1){1'b0}}};
            else                         r_s = {1'b0, {(OUT_BITWIDTH-1){1'b1}}};
        end else begin
            r_s = r_full_s[OUT_BITWIDTH-1:0];
        end
`endif
        win_ovf_s = (s1_first_r ? 1'b0 : ovf_win_r) | ovf_add_s;
    end

    // Stage 2 registers: running accumulator and the held window result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r       <= '0;
            ovf_win_r   <= 1'b0;
            out_r       <= '0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (adv_s && !s1_last_r) begin
                acc_r     <= r_s;
                ovf_win_r <= win_ovf_s;
            end
            if (adv_s && s1_last_r) begin
                out_r       <= r_s;
                ovf_r       <= win_ovf_s;
                out_valid_r <= 1'b1;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_pe.sv
// Self-checking bench for mac_dot_pe: directed cases plus randomized windows against a window-level model.
module tb_mac_dot_pe;

    localparam int LANES = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
`ifdef MAC_DOT_PE_SATURATE_EN
    localparam logic [63:0] OVF_EXP = 64'h7FFFFFFF;
`else
    localparam logic [63:0] OVF_EXP = 64'h7FFC0003;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready, ovf, busy;
    logic [63:0] a_in, w_in;
    logic [31:0] psum_in, out;
    logic [7:0]  acc_len;

    int n_cmp = 0, n_err = 0, out_cnt = 0, m_pushed = 0;
    int m_cnt = 0, m_len = 1;
    longint m_acc = 0;
    bit m_ovf = 1'b0, rand_done = 1'b0;
    logic [32:0] exp_q[$];
    int c0;

    mac_dot_pe #(.IN_BITWIDTH(16), .OUT_BITWIDTH(32), .LANES(LANES), .LEN_W(8), .SIGNED(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .w_in(w_in), .psum_in(psum_in), .acc_len(acc_len),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] x0, x1, x2, x3);
        return {x3, x2, x1, x0};
    endfunction

    // Window-level reference: exact integer dot product, range test, wrap or clamp.
    task automatic model_beat(input logic [63:0] a, w, input logic [31:0] ps, input logic [7:0] len);
        longint base, dot, full, res;
        logic signed [15:0] ai, wi;
        logic signed [31:0] t32;
        logic [63:0] fb;
        bit o;
        if (m_cnt == 0) begin
            m_len = (len == 8'd0) ? 1 : int'(len);
            t32 = ps;
            base = longint'(t32);
            m_ovf = 1'b0;
        end else begin
            base = m_acc;
        end
        dot = 0;
        for (int i = 0; i < LANES; i++) begin
            ai = a[i*16 +: 16];
            wi = w[i*16 +: 16];
            dot += longint'(ai) * longint'(wi);
        end
        full = base + dot;
        o = (full > SMAX) || (full < SMIN);
        m_ovf = m_ovf | o;
`ifdef MAC_DOT_PE_SATURATE_EN
        res = (full > SMAX) ? SMAX : ((full < SMIN) ? SMIN : full);
`else
        fb = full;
        t32 = fb[31:0];
        res = longint'(t32);
`endif
        m_cnt++;
        if (m_cnt == m_len) begin
            fb = res;
            exp_q.push_back({m_ovf, fb[31:0]});
            m_pushed++;
            m_cnt = 0;
        end else begin
            m_acc = res;
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, update the model at the accepting edge.
    task automatic send_beat(input logic [63:0] a, w, input logic [31:0] ps, input logic [7:0] len);
        int waited = 0;
        in_valid = 1'b1; a_in = a; w_in = w; psum_in = ps; acc_len = len;
        @(negedge clk);
        while (!in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            @(posedge clk);
            model_beat(a, w, ps, len);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain_queue", 64'(exp_q.size()), 64'd0);
        check_eq("drain_busy", 64'(busy), 64'd0);
    endtask

    // Output monitor: any valid result must match the oldest expected window.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", 64'(exp_q.size()), 64'd1);
            end else begin
                check_eq("out_value", 64'(out), 64'(exp_q[0][31:0]));
                check_eq("out_ovf", 64'(ovf), 64'(exp_q[0][32]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    out_cnt++;
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra, rw;
        logic [7:0]  rlen;
        int nb;
        reset = 1'b1; in_valid = 1'b0; a_in = '0; w_in = '0; psum_in = '0; acc_len = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out", 64'(out), 64'd0);
        check_eq("rst_ovf", 64'(ovf), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Single-beat dot product and T+2 latency.
        send_beat(pack4(16'd1, 16'd2, 16'd3, 16'd4), pack4(16'd5, 16'd6, 16'd7, 16'd8), 32'd10, 8'd1);
        check_eq("dot_lat_t1", 64'(out_valid), 64'd0);
        check_eq("dot_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check_eq("dot_lat_t2", 64'(out_valid), 64'd1);
        check_eq("dot_out", 64'(out), 64'd80);
        check_eq("dot_ovf", 64'(ovf), 64'd0);
        wait_drain();

        // Three-beat window then a back-to-back single-beat window.
        c0 = out_cnt;
        send_beat({4{16'd1}}, {4{16'd2}}, 32'd100, 8'd3);
        send_beat({4{16'd1}}, {4{16'd2}}, 32'd999, 8'd0);
        send_beat({4{16'd1}}, {4{16'd2}}, 32'd555, 8'd9);
        send_beat(64'd0, 64'd0, 32'd7, 8'd1);
        check_eq("win_out", 64'(out), 64'd124);
        @(posedge clk); #1;
        check_eq("win_next_valid", 64'(out_valid), 64'd1);
        check_eq("win_next_out", 64'(out), 64'd7);
        wait_drain();
        check_eq("win_out_count", 64'(out_cnt - c0), 64'd2);

        // Signed operands.
        send_beat({4{16'hFFFD}}, {4{16'd7}}, 32'hFFFFFFFB, 8'd1);
        @(posedge clk); #1;
        check_eq("signed_out", 64'(out), 64'hFFFFFFA7);
        wait_drain();

        // Overflow: wrap or clamp depending on build.
        send_beat({4{16'h7FFF}}, {4{16'h7FFF}}, 32'h7FFFFFFF, 8'd1);
        @(posedge clk); #1;
        check_eq("ovf_out", 64'(out), OVF_EXP);
        check_eq("ovf_flag", 64'(ovf), 64'd1);
        wait_drain();

        // Backpressure with a second last beat parked in stage 1.
        c0 = out_cnt;
        out_ready = 1'b0;
        send_beat({4{16'd1}}, {4{16'd1}}, 32'd0, 8'd1);
        send_beat({4{16'd2}}, {4{16'd2}}, 32'd0, 8'd1);
        for (int i = 0; i < 2; i++) begin
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            check_eq("bp_hold_out", 64'(out), 64'd4);
            @(posedge clk); #1;
        end
        fork
            send_beat(64'd0, 64'd0, 32'd5, 8'd1);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        check_eq("bp_second", 64'(out), 64'd16);
        wait_drain();
        check_eq("bp_out_count", 64'(out_cnt - c0), 64'd3);

        // Reset in the middle of a window discards it.
        send_beat({4{16'd1}}, {4{16'd2}}, 32'd100, 8'd3);
        send_beat({4{16'd1}}, {4{16'd2}}, 32'd100, 8'd3);
        reset = 1'b1;
        m_cnt = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
            check_eq("mid_rst_busy", 64'(busy), 64'd0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send_beat({4{16'd1}}, {4{16'd2}}, 32'd100, 8'd3);
        @(posedge clk); #1;
        check_eq("post_rst_out", 64'(out), 64'd124);
        wait_drain();

        // Randomized windows under random output backpressure.
        fork
            begin
                for (int k = 0; k < 120; k++) begin
                    rlen = 8'($urandom_range(0, 4));
                    nb = (rlen == 8'd0) ? 1 : int'(rlen);
                    for (int b = 0; b < nb; b++) begin
                        ra = {$urandom, $urandom};
                        rw = {$urandom, $urandom};
                        if ($urandom_range(0, 1) == 0) begin
                            ra = ra & 64'h00FF00FF00FF00FF;
                            rw = rw & 64'h01FF01FF01FF01FF;
                        end
                        send_beat(ra, rw, $urandom, (b == 0) ? rlen : 8'($urandom_range(0, 255)));
                        if ($urandom_range(0, 3) == 0) begin
                            repeat ($urandom_range(1, 3)) @(posedge clk);
                            #1;
                        end
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        check_eq("total_outs", 64'(out_cnt), 64'(m_pushed));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
